// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter state encoding, the default tag base and the WAIT_ACT guard length.
// No ports; imported by uart_tx_arbiter and rr_select users.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TAG       = 3'd1,
    ST_WAIT_ACT  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GRANTED   = 3'd4
  } arb_state_t;

  // Tag byte base; the owner index is OR-ed into the low bits.
  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

  // Cycles to wait in WAIT_ACT for uart_tx_active before giving up on it.
  localparam int WAIT_ACT_GUARD = 4;
  localparam int GUARD_W        = $clog2(WAIT_ACT_GUARD + 1);

  function automatic logic [7:0] tag_byte(input logic [7:0] base, input logic [7:0] idx);
    return base | idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin one-hot selector: picks the first set request at or after 'start', wrapping.
// Latency: purely combinational. Backpressure: none, caller decides when to latch the result.
// Ports: req (request vector), start (highest-priority index), gnt (one-hot), idx (binary), any.
module rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < N; k++) begin
      // Walk the ring starting at 'start'; the first hit wins.
      j = int'(start) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        gnt[jj] = 1'b1;
        idx     = jj;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ requesters; each granted frame is a tag byte then payload bytes.
// Latency: request to tag strobe 2 cycles (UART idle); granted byte strobe to uart_tx_send_byte 0 cycles.
// Backpressure: req_ready[owner] only in GRANTED; every byte waits for a full uart_tx_active low-high-low.
// Ports: clock/reset_n; req_frame/req_send_byte/req_byte in, req_ready/grant out (per requester);
//        uart_tx_send_byte/uart_tx_byte to uart_tx, uart_tx_active from it; frame_truncated sticky flag.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter int         MAX_BYTES = 256,
  parameter logic [7:0] TAG_BASE  = TAG_BASE_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_frame,
  input  logic [NUM_REQ-1:0]      req_send_byte,
  input  logic [NUM_REQ-1:0][7:0] req_byte,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    uart_tx_send_byte,
  output logic [7:0]              uart_tx_byte,
  input  logic                    uart_tx_active,
  output logic                    frame_truncated
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BYTES) + 1;

  localparam logic [CW-1:0]      CNT_MAX   = CW'(MAX_BYTES);
  localparam logic [GUARD_W-1:0] GUARD_END = GUARD_W'(WAIT_ACT_GUARD - 1);

  arb_state_t           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        ptr_q;      // index with highest priority at the next arbitration
  logic [CW-1:0]        cnt_q;      // payload bytes sent in the current frame
  logic [GUARD_W-1:0]   guard_q;
  logic                 tag_pulse_q;
  logic [7:0]           byte_q;
  logic                 trunc_q;
  logic [NUM_REQ-1:0]   blocked_q;  // truncated requesters still holding req_frame

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   sel_gnt;
  logic [IW-1:0]        sel_idx;
  logic                 sel_any;
  logic                 in_granted;
  logic                 owner_strobe;
  logic [IW-1:0]        next_ptr;

  assign eligible = req_frame & ~blocked_q;

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_select (
    .req   (eligible),
    .start (ptr_q),
    .gnt   (sel_gnt),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign in_granted   = (state_q == ST_GRANTED);
  assign owner_strobe = in_granted && req_send_byte[owner_q];
  assign next_ptr     = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

  // The payload strobe bypasses the register so the owner sees zero-cycle
  // forwarding; byte_q captures it on the same edge so the value stays put
  // for the rest of the character.
  assign req_ready         = in_granted ? grant_q : '0;
  assign grant             = grant_q;
  assign uart_tx_send_byte = tag_pulse_q | owner_strobe;
  assign uart_tx_byte      = owner_strobe ? req_byte[owner_q] : byte_q;
  assign frame_truncated   = trunc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      guard_q     <= '0;
      tag_pulse_q <= 1'b0;
      byte_q      <= '0;
      trunc_q     <= 1'b0;
      blocked_q   <= '0;
    end else begin
      tag_pulse_q <= 1'b0;
      // A truncated requester becomes eligible again once it lowers req_frame.
      blocked_q   <= blocked_q & req_frame;

      case (state_q)
        ST_IDLE: begin
          if (sel_any) begin
            grant_q <= sel_gnt;
            owner_q <= sel_idx;
            state_q <= ST_TAG;
          end
        end

        ST_TAG: begin
          // Also the restart point after reset: a character left in flight
          // by an abandoned frame must finish before the tag goes out.
          if (!uart_tx_active) begin
            tag_pulse_q <= 1'b1;
            byte_q      <= tag_byte(TAG_BASE, 8'(owner_q));
            cnt_q       <= '0;
            guard_q     <= '0;
            state_q     <= ST_WAIT_ACT;
          end
        end

        ST_WAIT_ACT: begin
          // Guard against a uart_tx that never reports busy.
          if (uart_tx_active || guard_q == GUARD_END) begin
            state_q <= ST_WAIT_DONE;
          end else begin
            guard_q <= guard_q + GUARD_W'(1);
          end
        end

        ST_WAIT_DONE: begin
          if (!uart_tx_active) begin
            if (cnt_q == CNT_MAX) begin
              grant_q   <= '0;
              ptr_q     <= next_ptr;
              trunc_q   <= 1'b1;
              blocked_q <= (blocked_q & req_frame) | (grant_q & req_frame);
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_GRANTED;
            end
          end
        end

        ST_GRANTED: begin
          // A strobe wins over a dropped frame; the release is then seen on
          // the next return to GRANTED.
          if (req_send_byte[owner_q]) begin
            byte_q  <= req_byte[owner_q];
            cnt_q   <= cnt_q + CW'(1);
            guard_q <= '0;
            state_q <= ST_WAIT_ACT;
          end else if (!req_frame[owner_q]) begin
            grant_q <= '0;
            ptr_q   <= next_ptr;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: random frames from two requesters against a byte-stream scoreboard.
// The UART is a behavioural model that goes busy for a random number of cycles per byte.
// Ports: none.
module tb_uart_tx_arbiter;

  localparam int         NR   = 2;
  localparam int         MAXB = 4;
  localparam logic [7:0] TAGB = 8'hA0;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NR-1:0]        req_frame = '0;
  logic [NR-1:0]        req_send_byte = '0;
  logic [NR-1:0][7:0]   req_byte = '0;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        grant;
  logic                 uart_tx_send_byte;
  logic [7:0]           uart_tx_byte;
  logic                 uart_tx_active = 1'b0;
  logic                 frame_truncated;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  int          ptr_m = 0;          // next requester to win when several ask at once
  bit          exp_trunc = 1'b0;
  int          uart_len_min = 2;
  int          uart_len_max = 6;
  logic [7:0]  pay [NR][8];
  bit          noise_stop = 1'b0;
  int          busy = 0;
  logic [7:0]  cur_byte = '0;
  bit          disturbed = 1'b0;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .MAX_BYTES (MAXB),
    .TAG_BASE  (TAGB)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_frame         (req_frame),
    .req_send_byte     (req_send_byte),
    .req_byte          (req_byte),
    .req_ready         (req_ready),
    .grant             (grant),
    .uart_tx_send_byte (uart_tx_send_byte),
    .uart_tx_byte      (uart_tx_byte),
    .uart_tx_active    (uart_tx_active),
    .frame_truncated   (frame_truncated)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART model and scoreboard monitor; samples mid-cycle, away from posedge.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("ready_within_grant", 32'(req_ready & ~grant), 0);
      if (uart_tx_send_byte) begin
        check("strobe_when_uart_idle", 32'(uart_tx_active), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, nothing expected (t=%0t)", uart_tx_byte, $time);
        end else begin
          check("uart_byte", 32'(uart_tx_byte), 32'(exp_q.pop_front()));
        end
        if (!uart_tx_active) begin
          uart_tx_active = 1'b1;
          busy           = $urandom_range(uart_len_max, uart_len_min);
          cur_byte       = uart_tx_byte;
          disturbed      = 1'b0;
        end
      end else if (uart_tx_active) begin
        busy--;
        if (busy <= 0) begin
          uart_tx_active = 1'b0;
          if (!disturbed) check("byte_stable", 32'(uart_tx_byte), 32'(cur_byte));
        end
      end
    end
  end

  task automatic wait_ready(input int idx, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("ready_arrives", 32'(ok), 1);
  endtask

  task automatic wait_release(input int idx);
    int t = 0;
    while (grant[idx] && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("grant_released", 32'(grant[idx]), 0);
  endtask

  // Drives one frame; expected bytes are pushed by the caller beforehand.
  task automatic drive_frame(input int idx, input int n, input bit drop_last, input bit check_lat);
    bit ok;
    int sent = 0;
    int k = 0;
    req_frame[idx] = 1'b1;
    if (check_lat) begin
      do begin
        @(negedge clock);
        #1;
        k++;
      end while (!uart_tx_send_byte && k < 10);
      check("tag_latency", 32'(k), 2);
    end
    while (sent < n && sent < MAXB) begin
      wait_ready(idx, ok);
      if (!ok) break;
      check("grant_owner", 32'(grant), 32'(1) << idx);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      req_byte[idx]      = pay[idx][sent];
      req_send_byte[idx] = 1'b1;
      if (drop_last && sent == n - 1) req_frame[idx] = 1'b0;
      #1;
      check("strobe_passthru", 32'(uart_tx_send_byte), 1);
      check("byte_passthru", 32'(uart_tx_byte), 32'(pay[idx][sent]));
      @(negedge clock);
      req_send_byte[idx] = 1'b0;
      sent++;
    end
    if (n >= MAXB) begin
      // Arbiter lets go by itself; further strobes with the frame held are ignored.
      wait_release(idx);
      for (int e = 0; e < n - MAXB + 3; e++) begin
        req_byte[idx]      = 8'($urandom);
        req_send_byte[idx] = (e < n - MAXB);
        #1;
        check("trunc_no_ready", 32'(req_ready[idx]), 0);
        check("trunc_no_regrant", 32'(grant[idx]), 0);
        @(negedge clock);
      end
      req_send_byte[idx] = 1'b0;
      req_frame[idx]     = 1'b0;
    end else begin
      if (!drop_last) req_frame[idx] = 1'b0;
      wait_release(idx);
    end
  endtask

  // Strobes from a requester that does not own the UART.
  task automatic noise(input int idx);
    while (!noise_stop) begin
      @(negedge clock);
      req_byte[idx]      = 8'($urandom);
      req_send_byte[idx] = 1'($urandom_range(0, 1));
      #1;
      check("nonowner_ready", 32'(req_ready[idx]), 0);
    end
    req_send_byte[idx] = 1'b0;
  endtask

  task automatic fill_pay(input int idx);
    for (int i = 0; i < 8; i++) pay[idx][i] = 8'($urandom);
  endtask

  task automatic single(input int idx, input int n, input bit drop_last, input bit check_lat);
    exp_q.push_back(TAGB | 8'(idx));
    for (int i = 0; i < n && i < MAXB; i++) exp_q.push_back(pay[idx][i]);
    if (n >= MAXB) exp_trunc = 1'b1;
    ptr_m      = (idx + 1) % NR;
    noise_stop = 1'b0;
    fork
      begin
        drive_frame(idx, n, drop_last, check_lat);
        noise_stop = 1'b1;
      end
      noise(1 - idx);
    join
  endtask

  // Both requesters raise req_frame together; the round-robin pointer picks the order.
  task automatic pair(input int n0, input int n1, input bit d0, input bit d1);
    int first  = ptr_m;
    int second = (ptr_m + 1) % NR;
    int nn[NR];
    nn[0] = n0;
    nn[1] = n1;
    exp_q.push_back(TAGB | 8'(first));
    for (int i = 0; i < nn[first]; i++) exp_q.push_back(pay[first][i]);
    exp_q.push_back(TAGB | 8'(second));
    for (int i = 0; i < nn[second]; i++) exp_q.push_back(pay[second][i]);
    ptr_m = (second + 1) % NR;
    fork
      drive_frame(0, n0, d0, 1'b0);
      drive_frame(1, n1, d1, 1'b0);
    join
  endtask

  task automatic settle();
    int t = 0;
    while ((uart_tx_active || grant != '0) && t < 1000) begin
      @(negedge clock);
      t++;
    end
    check("settle_idle", 32'(grant), 0);
    repeat (3) @(negedge clock);
    check("trunc_flag", 32'(frame_truncated), 32'(exp_trunc));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_grant", 32'(grant), 0);
    check("reset_ready", 32'(req_ready), 0);
    check("reset_send", 32'(uart_tx_send_byte), 0);
    check("reset_byte", 32'(uart_tx_byte), 0);
    check("reset_trunc", 32'(frame_truncated), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Simultaneous requests from reset: A0 frame, then A1 frame, then A0 again.
    repeat (2) begin
      fill_pay(0);
      fill_pay(1);
      pair(2, 3, 1'b0, 1'b0);
      settle();
    end

    // Single frame 11,22,33 with tag latency measured.
    pay[0][0] = 8'h11;
    pay[0][1] = 8'h22;
    pay[0][2] = 8'h33;
    single(0, 3, 1'b0, 1'b1);
    settle();

    // Six bytes against a four-byte limit.
    fill_pay(0);
    single(0, 6, 1'b0, 1'b0);
    settle();

    // Last strobe coincides with the frame drop.
    fill_pay(1);
    single(1, 2, 1'b1, 1'b0);
    settle();

    repeat (24) begin
      int idx;
      int n;
      fill_pay(0);
      fill_pay(1);
      if ($urandom_range(0, 2) == 0) begin
        pair($urandom_range(1, 3), $urandom_range(1, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        idx = $urandom_range(0, 1);
        n   = $urandom_range(1, 6);
        single(idx, n, (n < MAXB) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
      end
      settle();
    end

    // Reset while the tag is still on the line (arbiter in WAIT_DONE).
    uart_len_min = 14;
    uart_len_max = 14;
    exp_q.push_back(TAGB);
    req_frame[0] = 1'b1;
    t = 0;
    while (!uart_tx_active && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("tag_started", 32'(uart_tx_active), 1);
    repeat (2) @(negedge clock);
    #3;
    reset_n   = 1'b0;
    req_frame = '0;
    disturbed = 1'b1;
    #1;
    check("midreset_grant", 32'(grant), 0);
    check("midreset_ready", 32'(req_ready), 0);
    check("midreset_send", 32'(uart_tx_send_byte), 0);
    check("midreset_byte", 32'(uart_tx_byte), 0);
    check("midreset_trunc", 32'(frame_truncated), 0);
    ptr_m     = 0;
    exp_trunc = 1'b0;
    @(negedge clock);
    reset_n      = 1'b1;
    uart_len_min = 2;
    uart_len_max = 6;
    fill_pay(0);
    single(0, 2, 1'b0, 1'b0);
    settle();

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing uart_tx (2..4).
REQ-002 Parameter MAX_BYTES, default 256, maximum payload bytes per granted frame.
REQ-003 Parameter TAG_BASE, default 8'hA0, tag byte = TAG_BASE | requester index.
REQ-004 clock  input  1  system clock (50 MHz domain, same as uart_tx); one clock only.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 req_frame  input  NUM_REQ  per-requester frame request, held high for whole packet.
REQ-007 req_send_byte  input  NUM_REQ  per-requester byte strobe, honoured only while req_ready of that requester is high.
REQ-008 req_byte  input  NUM_REQ x 8  per-requester payload byte, sampled with req_send_byte.
REQ-009 req_ready  output  NUM_REQ  one-hot; high when granted requester may present its next byte.
REQ-010 grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-011 uart_tx_send_byte  output  1  one-cycle strobe to uart_tx.
REQ-012 uart_tx_byte  output  8  byte to uart_tx, stable from strobe until uart_tx_active falls.
REQ-013 uart_tx_active  input  1  uart_tx busy flag.
REQ-014 frame_truncated  output  1  sticky; set when a frame hits MAX_BYTES; cleared only by reset.

Function
REQ-015 FSM states: IDLE, TAG, WAIT_ACT, WAIT_DONE, GRANTED.
REQ-016 IDLE: when any req_frame is high, select next requester round-robin starting after last owner (index 0 first after reset); latch grant; go TAG.
REQ-017 TAG: when uart_tx_active=0, pulse uart_tx_send_byte with TAG_BASE|index; clear byte counter; go WAIT_ACT.
REQ-018 WAIT_ACT: go WAIT_DONE when uart_tx_active=1 or after 4 cycles without it (guard).
REQ-019 WAIT_DONE: when uart_tx_active=0, go GRANTED.
REQ-020 GRANTED: req_ready[owner]=1 combinationally; req_send_byte[owner]=1 -> latch req_byte[owner], pulse uart_tx_send_byte the same cycle, increment counter, go WAIT_ACT.
REQ-021 GRANTED with req_frame[owner]=0 and no strobe: release grant, update round-robin pointer, go IDLE.
REQ-022 Strobe and frame drop in the same cycle: byte is sent; release occurs on next entry to GRANTED.
REQ-023 Counter reaching MAX_BYTES: after that byte completes, release grant and set frame_truncated, even if req_frame still high; requester must drop req_frame for at least one cycle before it is eligible again.
REQ-024 Strobes from non-owners and strobes outside GRANTED are ignored; no data buffering beyond one byte.
REQ-025 Latency: IDLE request to tag strobe, 2 cycles when UART idle; GRANTED strobe to uart_tx_send_byte, 0 cycles.
REQ-026 Byte counter width clog2(MAX_BYTES)+1; no wrap-around.
REQ-027 At most one uart_tx_send_byte pulse per uart_tx_active low-high-low cycle.

Reset
REQ-028 Asynchronous assertion of reset_n low: FSM to IDLE, grant=0, req_ready=0, uart_tx_send_byte=0, uart_tx_byte=0, counter=0, RR pointer=0, frame_truncated=0.
REQ-029 Reset mid-frame abandons the frame; the byte already in uart_tx completes on the line, arbiter restarts in IDLE and waits for uart_tx_active=0 in TAG.

Structure
REQ-030 Shared package uart_arb_pkg holds state enum, TAG_BASE default and WAIT_ACT guard constant (4).
REQ-031 Round-robin selector is one sub-module rr_select (request vector + last index -> one-hot grant); rest flat.

Verification
REQ-032 req_frame=01, 3 bytes 11,22,33 -> UART stream A0,11,22,33; grant drops after frame low.
REQ-033 req_frame=11 simultaneously from reset -> A0 frame then A1 frame; repeat -> A0 again (round-robin).
REQ-034 Requester 1 strobes while 0 owns -> byte ignored, req_ready[1]=0 throughout.
REQ-035 MAX_BYTES=4, requester sends 6 -> A0 + 4 bytes, frame_truncated=1, no re-grant until frame toggles.
REQ-036 reset_n low during WAIT_DONE -> all outputs 0 immediately; after release, next tag waits for uart_tx_active=0.
REQ-037 Last strobe coincident with frame drop -> byte transmitted, then IDLE.
